// File: rtl/ind7seg_pkg.sv
// ---------------------------------------------------------------------------
// ind7seg_pkg
//   Shared definitions for the 7-segment scan controller:
//     - commit FSM state encoding
//     - segment-off pattern as a function of polarity
//     - hex glyph table (segments a..g in bits 0..6)
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ind7seg_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  // Pattern that turns every segment of one digit off.
  function automatic logic [7:0] off_pattern(input int active_low);
    return (active_low != 0) ? 8'hFF : 8'h00;
  endfunction

  // Standard 0-F glyphs, active-high, bit0 = a ... bit6 = g.
  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] hex_glyph(input logic [3:0] nibble);
    return HEX_GLYPH[nibble];
  endfunction

endpackage

`default_nettype wire

// File: rtl/counter.sv
// ---------------------------------------------------------------------------
// counter
//   Generic wrap-around counter 0..MAX with enable, direction and load.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset (count -> 0)
//     en              advance one step this cycle
//     updown          1 = count up (MAX wraps to 0), 0 = count down
//     load/load_value synchronous load, takes priority over en
//     count           current value
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module counter #(
  parameter int WIDTH = 4,
  parameter int MAX   = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             updown,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en) begin
      if (updown) begin
        count <= (count == MAX_V) ? '0 : count + 1'b1;
      end else begin
        count <= (count == '0) ? MAX_V : count - 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ind7seg_frame_buf.sv
// ---------------------------------------------------------------------------
// ind7seg_frame_buf
//   Double-buffered COUNT-digit segment store.
//   Optional macro: IND7SEG_HEX_DECODE_EN -- decode hex nibble + dp on the
//   write path; otherwise bytes are stored verbatim.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset (all entries OFF)
//     wr_en        completed host handshake this cycle
//     wr_addr      digit index; indices >= COUNT are dropped
//     wr_data      host byte
//     copy         front <= back (all digits, single edge)
//     blank        force OFF on data without touching the front buffer
//     data         front buffer, digit i in bits [i*8+7:i*8]
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ind7seg_frame_buf
  import ind7seg_pkg::*;
#(
  parameter int BITS           = 3,
  parameter int COUNT          = 8,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [BITS-1:0]    wr_addr,
  input  logic [7:0]         wr_data,
  input  logic               copy,
  input  logic               blank,
  output logic [COUNT*8-1:0] data
);

  localparam logic [7:0] OFF = off_pattern(SEG_ACTIVE_LOW);

  logic [7:0] back  [COUNT];
  logic [7:0] front [COUNT];
  logic [7:0] seg_byte;

`ifdef IND7SEG_HEX_DECODE_EN
  logic [7:0] seg_raw;
  logic       unused_bits;
  assign unused_bits = ^wr_data[6:4];
  assign seg_raw     = {wr_data[7], hex_glyph(wr_data[3:0])};
  assign seg_byte    = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
`else
  assign seg_byte = wr_data;
`endif

  // Address compare is done at 32 bits so out-of-range indices never alias
  // onto a real digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < COUNT; i++) begin
        back[i]  <= OFF;
        front[i] <= OFF;
      end
    end else begin
      for (int i = 0; i < COUNT; i++) begin
        if (wr_en && (32'(wr_addr) == i)) begin
          back[i] <= seg_byte;
        end
        if (copy) begin
          front[i] <= back[i];
        end
      end
    end
  end

  for (genvar g = 0; g < COUNT; g++) begin : g_data
    assign data[g*8 +: 8] = blank ? OFF : front[g];
  end

endmodule

`default_nettype wire

// File: rtl/ind7seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// ind7seg_scan_ctrl
//   Scan sequencer and tear-free frame-buffer controller for a multiplexed
//   7-segment driver.
//   Optional macro: IND7SEG_HEX_DECODE_EN (hex decode on the write path).
//   Ports:
//     clk          system clock, rising edge
//     rst          asynchronous reset, active-low
//     wr_valid/wr_ready/wr_addr/wr_data   host write port (back buffer)
//     commit       request back->front copy at the next frame boundary
//     commit_done  one-cycle pulse after the copy
//     blank        force all-off pattern on data
//     strobe       one-cycle pulse per digit dwell
//     frame_start  strobe that wraps the digit index to 0
//     data         displayed frame, digit i in bits [i*8+7:i*8]
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ind7seg_scan_ctrl
  import ind7seg_pkg::*;
#(
  parameter int BITS           = 3,
  parameter int COUNT          = 8,
  parameter int DIV            = 1000,
  parameter int DIV_BITS       = 10,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [BITS-1:0]    wr_addr,
  input  logic [7:0]         wr_data,
  input  logic               commit,
  output logic               commit_done,
  input  logic               blank,
  output logic               strobe,
  output logic               frame_start,
  output logic [COUNT*8-1:0] data
);

  logic [DIV_BITS-1:0] prescaler;
  logic [BITS-1:0]     digit;
  logic                boundary;
  logic                copy;
  state_t              state;

  counter #(.WIDTH(DIV_BITS), .MAX(DIV - 1)) u_prescaler (
    .clk        (clk),
    .rst_n      (rst),
    .en         (1'b1),
    .updown     (1'b1),
    .load       (1'b0),
    .load_value ('0),
    .count      (prescaler)
  );

  counter #(.WIDTH(BITS), .MAX(COUNT - 1)) u_digit (
    .clk        (clk),
    .rst_n      (rst),
    .en         (strobe),
    .updown     (1'b1),
    .load       (1'b0),
    .load_value ('0),
    .count      (digit)
  );

  assign strobe      = (prescaler == DIV_BITS'(DIV - 1));
  assign boundary    = strobe && (digit == BITS'(COUNT - 1));
  assign frame_start = boundary;
  assign wr_ready    = (state == ST_IDLE);
  // Only a commit already pending can copy; a commit arriving on a boundary
  // cycle waits a whole frame so the copy always lands on a clean wrap.
  assign copy        = (state == ST_PEND) && boundary;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      commit_done <= 1'b0;
    end else begin
      commit_done <= 1'b0;
      case (state)
        ST_IDLE: if (commit) state <= ST_PEND;
        ST_PEND: if (boundary) begin
          state       <= ST_IDLE;
          commit_done <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  ind7seg_frame_buf #(
    .BITS           (BITS),
    .COUNT          (COUNT),
    .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW)
  ) u_frame_buf (
    .clk     (clk),
    .rst_n   (rst),
    .wr_en   (wr_valid && wr_ready),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .copy    (copy),
    .blank   (blank),
    .data    (data)
  );

endmodule

`default_nettype wire

// File: doc/ind7seg_scan_ctrl.md
Name: ind7seg_scan_ctrl

Overview:
Scan sequencer and frame-buffer controller for the multiplexed 7-segment driver.
- Generates the driver's `strobe` from a clock prescaler.
- Tracks the driver's digit position.
- Owns a double-buffered COUNT-digit segment store written by a host over a valid/ready port.
- Presents the front buffer on the driver's `data` bus; host updates become visible only at a frame boundary (tear-free).

Parameters:
BITS, 3, width of digit index; must satisfy 2**BITS >= COUNT
COUNT, 8, number of digits
DIV, 1000, clk cycles per digit dwell; must be >= 2
DIV_BITS, 10, prescaler width; must satisfy 2**DIV_BITS >= DIV
SEG_ACTIVE_LOW, 0, 1 = segment-off pattern is 8'hFF, 0 = 8'h00

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
wr_valid  in  1  host write request
wr_ready  out  1  controller can accept a write
wr_addr  in  BITS  digit index to write
wr_data  in  8  segment byte (raw; see Optional Feature)
commit  in  1  request back-to-front copy at next frame boundary
commit_done  out  1  one-cycle pulse after the copy
blank  in  1  force all-off pattern on `data`
strobe  out  1  to driver `strobe`; one-cycle pulse per dwell
frame_start  out  1  pulse coincident with the `strobe` that wraps `digit` to 0
data  out  COUNT*8  to driver `data`; digit i occupies bits [i*8+7:i*8]

Behaviour:
- OFF = 8'hFF if SEG_ACTIVE_LOW, else 8'h00.
- Reset (rst low, asynchronous), held until release:
  - prescaler = 0, digit = 0, state = IDLE.
  - strobe = 0, frame_start = 0, commit_done = 0.
  - All back and front entries = OFF.
  - wr_ready = 1 (follows the state).
- Prescaler:
  - Counts 0..DIV-1 and wraps.
  - strobe = 1 for exactly the one cycle in which prescaler == DIV-1.
  - Period is DIV cycles; the first strobe is DIV cycles after reset release.
- Digit counter:
  - Advances on each strobe and wraps COUNT-1 -> 0, in lockstep with the driver's internal counter.
  - boundary = strobe && digit == COUNT-1; frame_start = boundary.
- Write port:
  - Handshake completes when wr_valid && wr_ready.
  - On completion, back[wr_addr] <= wr_data on that edge.
  - wr_addr >= COUNT: handshake completes, data is discarded.
  - Front buffer is never written by the host.
- FSM:
  - IDLE: wr_ready = 1. On commit go to PEND; a write in the same cycle as commit is applied and is included in the copy.
  - PEND: wr_ready = 0; commit is ignored. On boundary: front <= back (all digits, single edge), commit_done = 1 next cycle, go to IDLE.
  - Commit when boundary is in the same cycle: the copy waits for the next boundary; no same-cycle copy from IDLE.
- Output path:
  - data = blank ? {COUNT{OFF}} : front.
  - The blank path is combinational; the front buffer is preserved.
  - Because the copy happens on the edge where the driver wraps to digit 0, the new frame is displayed starting at digit 0.
- Reset mid-PEND aborts the commit: no commit_done, buffers return to OFF.

Optional Feature:
Macro IND7SEG_HEX_DECODE_EN.
- Defined:
  - wr_data[3:0] is a hex nibble; wr_data[7] is the decimal point; wr_data[6:4] is ignored.
  - The nibble is decoded to segments a-g (bits 0-6) with standard 0-F glyphs, dp -> bit 7.
  - Polarity follows SEG_ACTIVE_LOW.
  - Decode happens on the write path, so the buffers store segment bytes.
- Undefined: wr_data is stored verbatim and no decoder logic is present.

Decomposition:
- Shared package ind7seg_pkg holds:
  - FSM state encoding (IDLE, PEND).
  - OFF pattern function of SEG_ACTIVE_LOW.
  - Hex glyph constant table (16 x 7 bits).
- One natural sub-module, ind7seg_frame_buf: back and front arrays, write port, copy strobe, blank mux.
- Prescaler, digit counter and FSM stay in the top; the prescaler and digit counter reuse the existing `counter` block (updown = 1, load = 0).

Test Plan:
1. Reset: DIV=4, COUNT=4. Hold rst=0 for 3 cycles, release -> data=0, wr_ready=1, first strobe on cycle 4 after release, then every 4 cycles; frame_start on every 4th strobe.
2. Write then commit mid-frame: write addr 2 = 8'h5A, assert commit at digit 1 -> data unchanged and wr_ready=0 until the boundary edge; then data[23:16]=8'h5A and commit_done pulses once one cycle later.
3. Ignored requests: commit again while PEND, and wr_valid with wr_addr=5 (COUNT=4) -> second commit ignored; the out-of-range write is accepted with no buffer change.
4. Blank: set blank=1 with front holding 8'h5A -> data all zeros; clear blank -> 8'h5A restored immediately. Repeat with SEG_ACTIVE_LOW=1 -> blank yields all 8'hFF.
5. Reset mid-PEND: rst=0 during PEND -> immediate OFF outputs, no commit_done, state IDLE after release.
6. Hex decode: with IND7SEG_HEX_DECODE_EN, write 8'h83 to addr 0 and commit -> data[7:0]=8'hCF; without the macro -> data[7:0]=8'h83.
